uart_tx_frame: RTL and testbench

- Transmit-side counterpart of the UART command-frame parser: serialises one status frame onto the UART TX byte stream.
- Frame layout: 's', signal number, adder (4 bytes, MSB first), amplitude (4 bytes, MSB first), 'e'.
- Sits between the waveform-generator core registers and the UART TX byte interface (valid/ready), so the host can read back active settings.

---
 rtl/uart_frame_pkg.sv | 38 +++
 rtl/uart_tx_frame_if.sv | 11 +
 rtl/uart_frame_byte_sel.sv | 41 ++++
 rtl/uart_tx_frame.sv | 129 ++++++++++++
 tb/tb_uart_tx_frame.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// Shared UART frame definitions: delimiters, FSM states and byte-index map.
// UART_TX_FRAME_CHECKSUM_EN adds an XOR checksum byte ahead of EOM.
package uart_frame_pkg;

    localparam logic [7:0] SOM = 8'h73;
    localparam logic [7:0] EOM = 8'h65;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [3:0] IDX_SOM    = 4'd0;
    localparam logic [3:0] IDX_SIGNUM = 4'd1;
    localparam logic [3:0] IDX_ADDER0 = 4'd2;
    localparam logic [3:0] IDX_AMPL0  = 4'd6;
    localparam logic [3:0] IDX_CSUM   = 4'd10;

`ifdef UART_TX_FRAME_CHECKSUM_EN
    localparam logic [3:0] IDX_EOM   = 4'd11;
    localparam int         FRAME_LEN = 12;
`else
    localparam logic [3:0] IDX_EOM   = 4'd10;
    localparam int         FRAME_LEN = 11;
`endif

    // Byte k of a 32-bit word, most significant byte first.
    function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte-stream handshake toward the UART transmitter (valid/ready).
interface uart_tx_frame_if;

    logic [7:0] to_uart_data;
    logic       to_uart_valid;
    logic       to_uart_ready;

    modport master (output to_uart_data, output to_uart_valid, input to_uart_ready);
    modport slave  (input to_uart_data, input to_uart_valid, output to_uart_ready);

endinterface

// File: rtl/uart_frame_byte_sel.sv
// Combinational frame-index to byte mux over the snapshot registers.
// UART_TX_FRAME_CHECKSUM_EN adds the XOR checksum at IDX_CSUM.
import uart_frame_pkg::*;

module uart_frame_byte_sel (
    input  logic [3:0]  idx,
    input  logic [7:0]  signum,
    input  logic [31:0] adder,
    input  logic [31:0] amplitude,
    output logic [7:0]  frame_byte
);

`ifdef UART_TX_FRAME_CHECKSUM_EN
    logic [7:0] csum;
    assign csum = signum
                ^ adder[31:24] ^ adder[23:16] ^ adder[15:8] ^ adder[7:0]
                ^ amplitude[31:24] ^ amplitude[23:16] ^ amplitude[15:8] ^ amplitude[7:0];
`endif

    always_comb begin
        frame_byte = '0;
        case (idx)
            IDX_SOM:            frame_byte = SOM;
            IDX_SIGNUM:         frame_byte = signum;
            IDX_ADDER0:         frame_byte = be_byte(adder, 2'd0);
            IDX_ADDER0 + 4'd1:  frame_byte = be_byte(adder, 2'd1);
            IDX_ADDER0 + 4'd2:  frame_byte = be_byte(adder, 2'd2);
            IDX_ADDER0 + 4'd3:  frame_byte = be_byte(adder, 2'd3);
            IDX_AMPL0:          frame_byte = be_byte(amplitude, 2'd0);
            IDX_AMPL0 + 4'd1:   frame_byte = be_byte(amplitude, 2'd1);
            IDX_AMPL0 + 4'd2:   frame_byte = be_byte(amplitude, 2'd2);
            IDX_AMPL0 + 4'd3:   frame_byte = be_byte(amplitude, 2'd3);
`ifdef UART_TX_FRAME_CHECKSUM_EN
            IDX_CSUM:           frame_byte = csum;
`endif
            IDX_EOM:            frame_byte = EOM;
            default:            frame_byte = '0;
        endcase
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Serialises one status frame ('s', signum, adder, amplitude, 'e') onto the UART TX stream.
// UART_TX_FRAME_CHECKSUM_EN inserts an XOR checksum byte before 'e'.
import uart_frame_pkg::*;

module uart_tx_frame (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   send,
    input  logic [7:0]             signal_number,
    input  logic [31:0]            adder,
    input  logic [31:0]            amplitude,
    uart_tx_frame_if.master        tx,
    output logic                   busy,
    output logic                   done
);

    state_t      state, state_n;
    logic [3:0]  idx, idx_n, nxt_idx;
    logic [7:0]  data_q, data_n, nxt_byte;
    logic        valid_q, valid_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;
    logic        pend_q, pend_n;
    logic        snap_ld;
    logic [7:0]  snap_sig;
    logic [31:0] snap_add, snap_amp;

    // Output byte is registered; the mux looks one index ahead so the next
    // byte is ready the cycle after an accept.
    assign nxt_idx = idx + 4'd1;

    uart_frame_byte_sel u_sel (
        .idx        (nxt_idx),
        .signum     (snap_sig),
        .adder      (snap_add),
        .amplitude  (snap_amp),
        .frame_byte (nxt_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            pend_q  <= pend_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_sig <= '0;
            snap_add <= '0;
            snap_amp <= '0;
        end else if (snap_ld) begin
            snap_sig <= signal_number;
            snap_add <= adder;
            snap_amp <= amplitude;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        data_n  = data_q;
        valid_n = valid_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        pend_n  = pend_q;
        snap_ld = 1'b0;
        case (state)
            IDLE: begin
                if (send) begin
                    snap_ld = 1'b1;
                    idx_n   = IDX_SOM;
                    data_n  = SOM;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                pend_n = pend_q | send;
                if (tx.to_uart_ready) begin
                    if (idx == IDX_EOM) begin
                        valid_n = 1'b0;
                        data_n  = '0;
                        done_n  = 1'b1;
                        state_n = FINISH;
                    end else begin
                        idx_n  = nxt_idx;
                        data_n = nxt_byte;
                    end
                end
            end
            FINISH: begin
                // A request arriving here is honoured too, otherwise it would be lost.
                if (pend_q || send) begin
                    pend_n  = 1'b0;
                    snap_ld = 1'b1;
                    idx_n   = IDX_SOM;
                    data_n  = SOM;
                    valid_n = 1'b1;
                    state_n = SEND;
                end else begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign tx.to_uart_data  = data_q;
    assign tx.to_uart_valid = valid_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: table vectors, hand sequences, random frames vs a model.
module tb_uart_tx_frame;

    typedef logic [7:0] byte_q_t [$];

`ifdef UART_TX_FRAME_CHECKSUM_EN
    localparam int FLEN = 12;
`else
    localparam int FLEN = 11;
`endif

    typedef struct {
        logic [7:0]       sig;
        logic [31:0]      add;
        logic [31:0]      amp;
        bit               bp;
        logic [9:0][7:0]  exp;
        logic [7:0]       csum;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send = 1'b0;
    logic [7:0]  signal_number = '0;
    logic [31:0] adder = '0;
    logic [31:0] amplitude = '0;
    logic        busy, done;

    uart_tx_frame_if u_if ();

    uart_tx_frame dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .send          (send),
        .signal_number (signal_number),
        .adder         (adder),
        .amplitude     (amplitude),
        .tx            (u_if),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: accepted bytes, done pulses, stability under backpressure.
    logic [7:0] got_q [$];
    int         got_cyc [$];
    int         done_cnt = 0;
    int         stab_err = 0;
    logic       hold = 1'b0;
    logic [7:0] hold_data = '0;

    always @(negedge clk) begin
        if (rst_n && hold && (!u_if.to_uart_valid || u_if.to_uart_data !== hold_data))
            stab_err <= stab_err + 1;
        if (u_if.to_uart_valid && u_if.to_uart_ready) begin
            got_q.push_back(u_if.to_uart_data);
            got_cyc.push_back(cyc);
        end
        if (done) done_cnt <= done_cnt + 1;
        hold      <= u_if.to_uart_valid && !u_if.to_uart_ready;
        hold_data <= u_if.to_uart_data;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference frame built directly from the byte layout rules.
    function automatic byte_q_t model(input logic [7:0] s, input logic [31:0] a, input logic [31:0] m);
        byte_q_t q;
        q.push_back(8'h73);
        q.push_back(s);
        for (int i = 3; i >= 0; i--) q.push_back(a[8*i +: 8]);
        for (int i = 3; i >= 0; i--) q.push_back(m[8*i +: 8]);
`ifdef UART_TX_FRAME_CHECKSUM_EN
        begin
            logic [7:0] c;
            c = '0;
            for (int i = 1; i < q.size(); i++) c ^= q[i];
            q.push_back(c);
        end
`endif
        q.push_back(8'h65);
        return q;
    endfunction

    task automatic cmp_frame(input string nm, input int base, input byte_q_t exp);
        int errs;
        int first;
        errs = 0;
        first = -1;
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i >= got_q.size() || got_q[base+i] !== exp[i]) begin
                errs++;
                if (first < 0) first = i;
            end
        end
        chk($sformatf("%s bytes (errors, first bad idx %0d)", nm, first), errs, 0);
    endtask

    task automatic run_frame(input string nm, input logic [7:0] sig, input logic [31:0] add,
                             input logic [31:0] amp, input bit bp, input bit mutate, input byte_q_t exp);
        int base, d0, s0, sc, n;
        base = got_q.size();
        d0 = done_cnt;
        s0 = stab_err;
        n = 0;
        @(posedge clk); #1;
        signal_number = sig;
        adder = add;
        amplitude = amp;
        send = 1'b1;
        u_if.to_uart_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        sc = cyc;
        while (done_cnt == d0 && n < 400) begin
            @(posedge clk); #1;
            send = 1'b0;
            n++;
            if (bp) u_if.to_uart_ready = 1'($urandom_range(0, 1));
            if (mutate && n == 3) begin
                adder = 32'hFFFF_FFFF;
                amplitude = $urandom;
                signal_number = 8'($urandom);
            end
            @(negedge clk); #1;
        end
        chk({nm, " done seen"}, done_cnt - d0, 1);
        chk({nm, " byte count"}, got_q.size() - base, exp.size());
        cmp_frame(nm, base, exp);
        chk({nm, " stable under stall"}, stab_err - s0, 0);
        if (!bp && got_q.size() >= base + exp.size()) begin
            chk({nm, " first byte latency"}, got_cyc[base] - sc, 1);
            chk({nm, " back-to-back bytes"}, got_cyc[base+exp.size()-1] - got_cyc[base], exp.size() - 1);
        end
        @(posedge clk); #1;
        chk({nm, " busy after"}, busy, 0);
        chk({nm, " valid after"}, u_if.to_uart_valid, 0);
        @(negedge clk); #1;
        chk({nm, " single done"}, done_cnt - d0, 1);
    endtask

    vec_t    tbl [4];
    byte_q_t expq;

    initial begin
        int base, d0, n, busy_low, vcnt, cnt_at, dn_at;
        u_if.to_uart_ready = 1'b0;

        tbl[0] = '{8'h02, 32'h0000_3E80, 32'h000F_4240, 1'b0,
                   {8'h73, 8'h02, 8'h00, 8'h00, 8'h3E, 8'h80, 8'h00, 8'h0F, 8'h42, 8'h40}, 8'hB1};
        tbl[1] = '{8'h02, 32'h0000_3E80, 32'h000F_4240, 1'b1,
                   {8'h73, 8'h02, 8'h00, 8'h00, 8'h3E, 8'h80, 8'h00, 8'h0F, 8'h42, 8'h40}, 8'hB1};
        tbl[2] = '{8'hA5, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0,
                   {8'h73, 8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67}, 8'h87};
        tbl[3] = '{8'h00, 32'h0000_0000, 32'h0000_0000, 1'b1,
                   {8'h73, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h00};

        // Reset state
        @(posedge clk); #1;
        chk("reset data", u_if.to_uart_data, 0);
        chk("reset valid", u_if.to_uart_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Table vectors
        for (int i = 0; i < 4; i++) begin
            expq = {};
            for (int j = 9; j >= 0; j--) expq.push_back(tbl[i].exp[j]);
`ifdef UART_TX_FRAME_CHECKSUM_EN
            expq.push_back(tbl[i].csum);
`endif
            expq.push_back(8'h65);
            run_frame($sformatf("vec%0d", i), tbl[i].sig, tbl[i].add, tbl[i].amp, tbl[i].bp, 1'b0, expq);
        end

        // Snapshot isolation: inputs change while the frame is in flight
        run_frame("isolate", 8'h02, 32'h0000_3E80, 32'h000F_4240, 1'b0, 1'b1,
                  model(8'h02, 32'h0000_3E80, 32'h000F_4240));

        // Pending: one send mid-frame, one in the last-byte accept cycle
        base = got_q.size();
        d0 = done_cnt;
        n = 0;
        busy_low = 0;
        @(posedge clk); #1;
        signal_number = 8'h02;
        adder = 32'h0000_3E80;
        amplitude = 32'h000F_4240;
        send = 1'b1;
        u_if.to_uart_ready = 1'b1;
        while (done_cnt < d0 + 2 && n < 400) begin
            @(posedge clk); #1;
            n++;
            send = (n == 3 || n == FLEN);
            if (n == 3) amplitude = 32'h0000_0001;
            @(negedge clk); #1;
            if (done_cnt < d0 + 2 && !busy) busy_low++;
        end
        send = 1'b0;
        chk("pend done pulses", done_cnt - d0, 2);
        chk("pend byte count", got_q.size() - base, 2 * FLEN);
        cmp_frame("pend frame1", base, model(8'h02, 32'h0000_3E80, 32'h000F_4240));
        cmp_frame("pend frame2", base + FLEN, model(8'h02, 32'h0000_3E80, 32'h0000_0001));
        if (got_q.size() >= base + FLEN + 1)
            chk("pend gap cycles", got_cyc[base+FLEN] - got_cyc[base+FLEN-1], 2);
        chk("pend busy held", busy_low, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("pend no third frame", got_q.size() - base, 2 * FLEN);
        chk("pend busy after", busy, 0);

        // Reset mid-frame at byte index 5
        @(posedge clk); #1;
        send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre-reset valid", u_if.to_uart_valid, 1);
        dn_at = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid-rst valid", u_if.to_uart_valid, 0);
        chk("mid-rst data", u_if.to_uart_data, 0);
        chk("mid-rst busy", busy, 0);
        chk("mid-rst done", done, 0);
        cnt_at = got_q.size();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            u_if.to_uart_ready = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            if (u_if.to_uart_valid) vcnt++;
        end
        chk("post-rst idle valid", vcnt, 0);
        chk("post-rst no bytes", got_q.size() - cnt_at, 0);
        chk("post-rst no done", done_cnt - dn_at, 0);
        run_frame("post-rst frame", 8'h5A, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0,
                  model(8'h5A, 32'h1234_5678, 32'h9ABC_DEF0));

        // Random frames against the model
        for (int i = 0; i < 12; i++) begin
            logic [7:0]  s;
            logic [31:0] a, m;
            bit          bp, mu;
            s = 8'($urandom);
            a = $urandom;
            m = $urandom;
            bp = 1'($urandom_range(0, 1));
            mu = 1'($urandom_range(0, 1));
            run_frame($sformatf("rand%0d", i), s, a, m, bp, mu, model(s, a, m));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
